vector_scalar_reduce_unit: RTL and testbench

Pipeline stage directly downstream of the filter/reduce unit in the trace datapath. It consumes the N-lane vectors that stage produces and applies a per-chain firmware operation: bypass, in-vector sum to a scalar, or element-wise accumulation across vectors until end-of-frame. Results go to the vector-vector ALU / data packer stage, using the same valid/eof/chainId sideband.

---
 rtl/vector_scalar_reduce_unit_pkg.sv | 18 +
 rtl/vsru_chain_accumulator.sv | 45 ++++
 rtl/vector_scalar_reduce_unit.sv | 161 ++++++++++++++++
 tb/tb_vector_scalar_reduce_unit.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vector_scalar_reduce_unit_pkg.sv
// Shared types and constants for the vector scalar/reduce stage.
package vector_scalar_reduce_unit_pkg;

    localparam int N_LANES  = 8;
    localparam int DATA_W   = 32;
    localparam int N_CHAINS = 4;

    localparam logic [7:0] OP_BYPASS = 8'd0;
    localparam logic [7:0] OP_SUM    = 8'd1;
    localparam logic [7:0] OP_ACC    = 8'd2;

    typedef logic [N_LANES-1:0][DATA_W-1:0] lane_vec_t;

    function automatic int chain_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/vsru_chain_accumulator.sv
// Per-chain lane accumulators; sum is acc[chain] + vec, written back on acc_en.
module vsru_chain_accumulator #(
    parameter int N          = 8,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_CHAINS = 4,
    parameter int CW         = 2
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           acc_en,
    input  logic                           clr,
    input  logic [CW-1:0]                  chain,
    input  logic [N-1:0][DATA_WIDTH-1:0]   vec,
    output logic [N-1:0][DATA_WIDTH-1:0]   sum
);

    logic [N-1:0][DATA_WIDTH-1:0] acc_q [MAX_CHAINS];
    logic [N-1:0][DATA_WIDTH-1:0] acc_d [MAX_CHAINS];

    // Reading acc_q here sees the previous cycle's write, so back-to-back
    // vectors on one chain chain together without a separate bypass path.
    always_comb begin
        for (int k = 0; k < N; k++) begin
            sum[k] = acc_q[chain][k] + vec[k];
        end
    end

    always_comb begin
        acc_d = acc_q;
        if (acc_en) begin
            acc_d[chain] = clr ? '0 : sum;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int c = 0; c < MAX_CHAINS; c++) begin
                acc_q[c] <= '0;
            end
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/vector_scalar_reduce_unit.sv
// Two-stage vector stage: per-chain bypass, lane sum, or frame accumulate.
module vector_scalar_reduce_unit
    import vector_scalar_reduce_unit_pkg::*;
#(
    parameter int                          N                   = N_LANES,
    parameter int                          DATA_WIDTH          = DATA_W,
    parameter int                          MAX_CHAINS          = N_CHAINS,
    parameter logic [7:0]                  PERSONAL_CONFIG_ID  = 8'd1,
    parameter logic [MAX_CHAINS-1:0][7:0]  INITIAL_FIRMWARE_OP = '0,
    localparam int                         CW = chain_w(MAX_CHAINS)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         tracing,
    input  logic                         valid_in,
    input  logic                         eof_in,
    input  logic [CW-1:0]                chainId_in,
    input  logic [7:0]                   configId,
    input  logic [7:0]                   configData,
    input  logic [N-1:0][DATA_WIDTH-1:0] vector_in,
    output logic [N-1:0][DATA_WIDTH-1:0] vector_out,
    output logic [CW-1:0]                chainId_out,
    output logic                         valid_out,
    output logic                         eof_out
);

    logic [MAX_CHAINS-1:0][7:0]   fw_q, fw_d;
    logic [CW-1:0]                ptr_q, ptr_d;

    logic                         s1_valid_q, s1_valid_d;
    logic                         s1_eof_q, s1_eof_d;
    logic [CW-1:0]                s1_chain_q, s1_chain_d;
    logic [7:0]                   s1_op_q, s1_op_d;
    logic [N-1:0][DATA_WIDTH-1:0] s1_vec_q, s1_vec_d;

    logic [N-1:0][DATA_WIDTH-1:0] vec_out_q, vec_out_d;
    logic [CW-1:0]                chain_out_q, chain_out_d;
    logic                         valid_out_q, valid_out_d;
    logic                         eof_out_q, eof_out_d;

    logic                         fire;
    logic                         is_sum;
    logic                         is_acc;
    logic                         acc_en;
    logic                         acc_clr;
    logic [DATA_WIDTH-1:0]        lane_sum;
    logic [N-1:0][DATA_WIDTH-1:0] acc_sum;

    // Stage 1 looks up fw_q before this cycle's config write lands.
    always_comb begin
        fw_d  = fw_q;
        ptr_d = ptr_q;
        if (configId == PERSONAL_CONFIG_ID) begin
            fw_d[ptr_q] = configData;
            ptr_d = (ptr_q == CW'(MAX_CHAINS - 1)) ? '0 : ptr_q + CW'(1);
        end
    end

    always_comb begin
        s1_valid_d = tracing & valid_in;
        s1_eof_d   = eof_in;
        s1_chain_d = chainId_in;
        s1_op_d    = fw_q[chainId_in];
        s1_vec_d   = vector_in;
    end

    always_comb begin
        lane_sum = '0;
        for (int k = 0; k < N; k++) begin
            lane_sum = lane_sum + s1_vec_q[k];
        end
    end

    vsru_chain_accumulator #(
        .N          (N),
        .DATA_WIDTH (DATA_WIDTH),
        .MAX_CHAINS (MAX_CHAINS),
        .CW         (CW)
    ) u_acc (
        .clk    (clk),
        .reset  (reset),
        .acc_en (acc_en),
        .clr    (acc_clr),
        .chain  (s1_chain_q),
        .vec    (s1_vec_q),
        .sum    (acc_sum)
    );

    always_comb begin
        fire        = tracing & s1_valid_q;
        is_sum      = (s1_op_q == OP_SUM);
        is_acc      = (s1_op_q == OP_ACC);
        vec_out_d   = vec_out_q;
        chain_out_d = chain_out_q;
        valid_out_d = 1'b0;
        eof_out_d   = 1'b0;
        acc_en      = 1'b0;
        acc_clr     = 1'b0;
        if (fire) begin
            unique case (1'b1)
                is_acc: begin
                    acc_en  = 1'b1;
                    acc_clr = s1_eof_q;
                    if (s1_eof_q) begin
                        valid_out_d = 1'b1;
                        eof_out_d   = 1'b1;
                        chain_out_d = s1_chain_q;
                        vec_out_d   = acc_sum;
                    end
                end
                is_sum: begin
                    valid_out_d  = 1'b1;
                    eof_out_d    = s1_eof_q;
                    chain_out_d  = s1_chain_q;
                    vec_out_d    = '0;
                    vec_out_d[0] = lane_sum;
                end
                default: begin
                    valid_out_d = 1'b1;
                    eof_out_d   = s1_eof_q;
                    chain_out_d = s1_chain_q;
                    vec_out_d   = s1_vec_q;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fw_q        <= INITIAL_FIRMWARE_OP;
            ptr_q       <= '0;
            s1_valid_q  <= 1'b0;
            s1_eof_q    <= 1'b0;
            s1_chain_q  <= '0;
            s1_op_q     <= OP_BYPASS;
            s1_vec_q    <= '0;
            vec_out_q   <= '0;
            chain_out_q <= '0;
            valid_out_q <= 1'b0;
            eof_out_q   <= 1'b0;
        end else begin
            fw_q        <= fw_d;
            ptr_q       <= ptr_d;
            s1_valid_q  <= s1_valid_d;
            s1_eof_q    <= s1_eof_d;
            s1_chain_q  <= s1_chain_d;
            s1_op_q     <= s1_op_d;
            s1_vec_q    <= s1_vec_d;
            vec_out_q   <= vec_out_d;
            chain_out_q <= chain_out_d;
            valid_out_q <= valid_out_d;
            eof_out_q   <= eof_out_d;
        end
    end

    assign vector_out  = vec_out_q;
    assign chainId_out = chain_out_q;
    assign valid_out   = valid_out_q;
    assign eof_out     = eof_out_q;

endmodule

// File: tb/tb_vector_scalar_reduce_unit.sv
// Directed bench for vector_scalar_reduce_unit with hand-computed vectors.
module tb_vector_scalar_reduce_unit;

    logic             clk = 1'b0;
    logic             reset;
    logic             tracing;
    logic             valid_in;
    logic             eof_in;
    logic [1:0]       chainId_in;
    logic [7:0]       configId;
    logic [7:0]       configData;
    logic [7:0][31:0] vector_in;
    logic [7:0][31:0] vector_out;
    logic [1:0]       chainId_out;
    logic             valid_out;
    logic             eof_out;

    int n_chk  = 0;
    int n_pass = 0;

    logic [255:0] seq_v;
    logic [7:0]   cfg_b [5];

    always #5 clk = ~clk;

    vector_scalar_reduce_unit dut (
        .clk         (clk),
        .reset       (reset),
        .tracing     (tracing),
        .valid_in    (valid_in),
        .eof_in      (eof_in),
        .chainId_in  (chainId_in),
        .configId    (configId),
        .configData  (configData),
        .vector_in   (vector_in),
        .vector_out  (vector_out),
        .chainId_out (chainId_out),
        .valid_out   (valid_out),
        .eof_out     (eof_out)
    );

    task automatic check(input string tag, input logic [255:0] got,
                         input logic [255:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic check_out(input string tag, input logic ev,
                             input logic ee, input logic [1:0] ec,
                             input logic [255:0] evec);
        check({tag, "_valid"}, 256'(valid_out), 256'(ev));
        if (ev) begin
            check({tag, "_eof"}, 256'(eof_out), 256'(ee));
            check({tag, "_chain"}, 256'(chainId_out), 256'(ec));
            check({tag, "_vec"}, vector_out, evec);
        end
    endtask

    function automatic logic [255:0] fill(input logic [31:0] x);
        logic [255:0] r;
        for (int k = 0; k < 8; k++) r[k*32 +: 32] = x;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        valid_in   = 1'b0;
        eof_in     = 1'b0;
        chainId_in = '0;
        vector_in  = '0;
    endtask

    task automatic drive(input logic [1:0] c, input logic e,
                         input logic [255:0] v);
        valid_in   = 1'b1;
        eof_in     = e;
        chainId_in = c;
        vector_in  = v;
    endtask

    task automatic cfg_write(input logic [7:0] b);
        configId   = 8'd1;
        configData = b;
        tick();
        configId   = 8'd0;
    endtask

    initial begin
        for (int k = 0; k < 8; k++) seq_v[k*32 +: 32] = 32'(k + 1);
        cfg_b = '{8'h01, 8'h02, 8'h00, 8'h01, 8'h02};
        idle();
        configId   = 8'd0;
        configData = 8'd0;
        tracing    = 1'b1;
        reset      = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        check("rst_valid", 256'(valid_out), 256'(0));
        check("rst_eof", 256'(eof_out), 256'(0));
        check("rst_chain", 256'(chainId_out), 256'(0));
        check("rst_vec", vector_out, 256'(0));

        // bypass on chain 0, two-cycle latency
        drive(2'd0, 1'b0, seq_v);
        tick();
        idle();
        check("byp_lat1", 256'(valid_out), 256'(0));
        tick();
        check_out("byp", 1'b1, 1'b0, 2'd0, seq_v);

        // table -> [0,1,2,2]
        cfg_write(8'h00);
        cfg_write(8'h01);
        cfg_write(8'h02);
        cfg_write(8'h02);

        drive(2'd1, 1'b1, seq_v);
        tick();
        idle();
        tick();
        check_out("sum", 1'b1, 1'b1, 2'd1, 256'd36);

        drive(2'd2, 1'b0, fill(32'd3));
        tick();
        drive(2'd2, 1'b0, fill(32'd3));
        tick();
        check("acc_a", 256'(valid_out), 256'(0));
        drive(2'd2, 1'b1, fill(32'd3));
        tick();
        check("acc_b", 256'(valid_out), 256'(0));
        idle();
        tick();
        check_out("acc_eof", 1'b1, 1'b1, 2'd2, fill(32'd9));
        drive(2'd2, 1'b1, fill(32'd1));
        tick();
        idle();
        tick();
        check_out("acc_clr", 1'b1, 1'b1, 2'd2, fill(32'd1));

        // interleaved chains 2 and 3
        drive(2'd2, 1'b0, fill(32'd1));
        tick();
        drive(2'd3, 1'b0, fill(32'd1));
        tick();
        check("il_a", 256'(valid_out), 256'(0));
        drive(2'd2, 1'b1, fill(32'd1));
        tick();
        check("il_b", 256'(valid_out), 256'(0));
        drive(2'd3, 1'b1, fill(32'd1));
        tick();
        check_out("il_c2", 1'b1, 1'b1, 2'd2, fill(32'd2));
        idle();
        tick();
        check_out("il_c3", 1'b1, 1'b1, 2'd3, fill(32'd2));

        // tracing=0 drops traffic, accumulators hold
        drive(2'd2, 1'b0, fill(32'd4));
        tick();
        idle();
        tick();
        tracing = 1'b0;
        drive(2'd2, 1'b1, fill(32'd100));
        tick();
        tick();
        check("trc_off", 256'(valid_out), 256'(0));
        tracing = 1'b1;
        idle();
        tick();
        drive(2'd2, 1'b1, fill(32'd2));
        tick();
        idle();
        tick();
        check_out("trc_hold", 1'b1, 1'b1, 2'd2, fill(32'd6));

        // table -> [2,2,0,1]; last write shares a cycle with a chain-0 vector
        for (int i = 0; i < 5; i++) begin
            configId   = 8'd1;
            configData = cfg_b[i];
            if (i == 4) drive(2'd0, 1'b1, seq_v);
            tick();
        end
        configId = 8'd0;
        idle();
        tick();
        check_out("cfg_old_op", 1'b1, 1'b1, 2'd0, 256'd36);

        drive(2'd0, 1'b1, seq_v);
        tick();
        idle();
        tick();
        check_out("cfg_c0_acc", 1'b1, 1'b1, 2'd0, seq_v);
        drive(2'd2, 1'b0, seq_v);
        tick();
        idle();
        tick();
        check_out("cfg_c2_byp", 1'b1, 1'b0, 2'd2, seq_v);
        drive(2'd3, 1'b1, seq_v);
        tick();
        idle();
        tick();
        check_out("cfg_c3_sum", 1'b1, 1'b1, 2'd3, 256'd36);
        drive(2'd1, 1'b0, fill(32'd5));
        tick();
        drive(2'd1, 1'b1, fill(32'd5));
        tick();
        check("cfg_c1_a", 256'(valid_out), 256'(0));
        idle();
        tick();
        check_out("cfg_c1_acc", 1'b1, 1'b1, 2'd1, fill(32'd10));

        // modulo wrap
        drive(2'd1, 1'b0, fill(32'hFFFF_FFFF));
        tick();
        drive(2'd1, 1'b1, fill(32'd2));
        tick();
        check("ovf_a", 256'(valid_out), 256'(0));
        idle();
        tick();
        check_out("ovf", 1'b1, 1'b1, 2'd1, fill(32'd1));

        // reset mid-frame discards partial sum and in-flight vector
        drive(2'd1, 1'b0, fill(32'hFFFF_FFFF));
        tick();
        drive(2'd1, 1'b1, fill(32'd7));
        tick();
        idle();
        reset = 1'b1;
        tick();
        check("rst_inflight", 256'(valid_out), 256'(0));
        reset = 1'b0;
        tick();
        check("rst_after", 256'(valid_out), 256'(0));
        check("rst_after_vec", vector_out, 256'(0));
        cfg_write(8'h00);
        cfg_write(8'h02);
        drive(2'd1, 1'b1, fill(32'd5));
        tick();
        idle();
        tick();
        check_out("rst_acc", 1'b1, 1'b1, 2'd1, fill(32'd5));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
